clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Timekeeping and time-setting controller for the 24-hour clock. It consumes the one-cycle debounced button pulses from the button input stage and sequences a three-state setting FSM. It keeps the hour/minute/second counters, advanced by an internal 1 s prescaler. Its outputs feed the display decoder: time digits in binary, current mode, and field-blank flags for blinking the field being set.

## Interface
- CLK_FREQ, default 48000000: CLK cycles per second. Minimum 4. Benches use a small value.
- CLK  input  1  system clock; all state updates on its rising edge
- RST  input  1  synchronous reset, active-low; sampled on the CLK rising edge
- BTN  input  3  debounced button pulses, each high for exactly one CLK cycle per press. BTN[0]=MODE, BTN[1]=UP, BTN[2]=SEC_CLR.
- HOUR  output  5  hours, 0–23
- MIN  output  6  minutes, 0–59
- SEC  output  6  seconds, 0–59
- MODE  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN; the value 3 never appears
- BLANK_H  output  1  high when the display must blank the hour digits
- BLANK_M  output  1  high when the display must blank the minute digits
- DAY_PULSE  output  1  one-cycle pulse on rollover from 23:59:59 to 00:00:00

## Operation
- Reset (RST low at a clock edge): all outputs 0 and prescaler 0.
- Prescaler:
  - Counts 0..CLK_FREQ-1, then wraps to 0. It runs in every mode.
  - tick = (prescaler == CLK_FREQ-1).
  - half = (prescaler >= CLK_FREQ/2), using integer division.
- FSM, advanced by MODE pulses: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - On the SET_MIN -> RUN transition, SEC and the prescaler are cleared to 0. Counting restarts from a full second.
- RUN state:
  - On tick, SEC increments.
  - SEC 59 -> 0 carries into MIN; MIN 59 -> 0 carries into HOUR; HOUR 23 -> 0.
  - DAY_PULSE is asserted on the edge where 23:59:59 becomes 00:00:00.
  - UP is ignored in RUN.
- SET_HOUR / SET_MIN states:
  - Timekeeping is frozen and tick has no effect on the time.
  - UP increments only the selected field, wrapping 23 -> 0 (HOUR) or 59 -> 0 (MIN).
  - No carry into other fields and no DAY_PULSE.
- SEC_CLR, in any mode: SEC <= 0 and prescaler <= 0. In RUN, the tick coinciding with SEC_CLR is discarded.
- Blanking:
  - BLANK_H = (MODE==SET_HOUR) & half.
  - BLANK_M = (MODE==SET_MIN) & half.
  - Both are 0 in RUN.
- Simultaneous pulses in one cycle:
  - MODE takes priority and the UP in that cycle is ignored.
  - SEC_CLR is always applied, in addition to whatever else happens that cycle.
- Out-of-range BTN patterns do not exist: each bit is independent.

## Timing
- All outputs are registered.
- A button pulse seen at edge N is reflected in the outputs after edge N.
- Tick latency: SEC changes at the edge where the prescaler wraps, i.e. every CLK_FREQ cycles in RUN.
- After reset release (first edge with RST high), the first SEC increment occurs at edge CLK_FREQ.
- DAY_PULSE is high for exactly the one cycle following the rollover edge.
- BLANK flags are registered from the prescaler value. They toggle at prescaler = CLK_FREQ/2 and at the wrap, one cycle after the compare.
- Reset mid-operation, including during a SET state: returns to RUN at 00:00:00 on that edge, and any pending pulse is lost.

## Test plan
- Counting and rollover: CLK_FREQ=10, preset via SET to 23:59 with SEC reaching 59, run 10 cycles -> HOUR=0, MIN=0, SEC=0, DAY_PULSE high for one cycle.
- Setting sequence: MODE, UP×25, MODE, UP×61, MODE -> MODE steps 1, 2, 0; HOUR=1, MIN=1, SEC=0, and no DAY_PULSE throughout.
- Freeze: in SET_HOUR, hold for 35 cycles (CLK_FREQ=10) -> SEC unchanged; BLANK_H toggles at a 5-cycle half period; BLANK_M=0.
- Simultaneous events: MODE and UP in the same cycle while in RUN -> MODE=1 and HOUR unchanged. SEC_CLR on the tick cycle -> SEC=0 and the prescaler restarts; the next increment comes 10 cycles later.
- Reset mid-operation: RST low while in SET_MIN at 05:07 -> after that edge MODE=0, all time fields 0, BLANK flags 0.
- UP in RUN is ignored: 3 UP pulses -> HOUR and MIN unchanged.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   24-hour timekeeping and time-setting controller. A free-running 1 s
//   prescaler advances SEC/MIN/HOUR in RUN. MODE button pulses walk a
//   three-state setting FSM, and the UP button adjusts the field being set.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous reset, active low
//   BTN[2:0]  in   one-cycle button pulses: [0]=MODE, [1]=UP, [2]=SEC_CLR
//   HOUR      out  hours 0..23
//   MIN       out  minutes 0..59
//   SEC       out  seconds 0..59
//   MODE      out  0=RUN, 1=SET_HOUR, 2=SET_MIN
//   BLANK_H   out  blank hour digits (blinks while setting hours)
//   BLANK_M   out  blank minute digits (blinks while setting minutes)
//   DAY_PULSE out  one-cycle pulse on 23:59:59 -> 00:00:00
//
// state    | meaning
// S_RUN    | normal timekeeping, UP ignored
// S_HOUR   | time frozen, UP increments HOUR
// S_MIN    | time frozen, UP increments MIN; leaving clears SEC and prescaler
module clock_set_ctrl #(
  parameter int CLK_FREQ = 48000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] BTN,
  output logic [4:0] HOUR,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic [1:0] MODE,
  output logic       BLANK_H,
  output logic       BLANK_M,
  output logic       DAY_PULSE
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [4:0]    hour_n;
  logic [5:0]    min_n, sec_n;
  logic          blank_h_n, blank_m_n, day_n;
  logic          tick, half;
  logic          btn_mode, btn_up, btn_clr;

  assign btn_mode = BTN[0];
  assign btn_up   = BTN[1];
  assign btn_clr  = BTN[2];
  assign tick     = (presc == PRESC_LAST);
  assign half     = (presc >= PRESC_HALF);
  assign MODE     = state;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_RUN;
      presc     <= '0;
      HOUR      <= '0;
      MIN       <= '0;
      SEC       <= '0;
      BLANK_H   <= 1'b0;
      BLANK_M   <= 1'b0;
      DAY_PULSE <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      HOUR      <= hour_n;
      MIN       <= min_n;
      SEC       <= sec_n;
      BLANK_H   <= blank_h_n;
      BLANK_M   <= blank_m_n;
      DAY_PULSE <= day_n;
    end
  end

  always_comb begin
    state_n   = state;
    presc_n   = tick ? '0 : presc + PW'(1);
    hour_n    = HOUR;
    min_n     = MIN;
    sec_n     = SEC;
    day_n     = 1'b0;
    blank_h_n = (state == S_HOUR) && half;
    blank_m_n = (state == S_MIN) && half;

    // A tick that coincides with SEC_CLR is dropped rather than applied.
    if (state == S_RUN && tick && !btn_clr) begin
      if (SEC == 6'd59) begin
        sec_n = '0;
        if (MIN == 6'd59) begin
          min_n = '0;
          if (HOUR == 5'd23) begin
            hour_n = '0;
            day_n  = 1'b1;
          end else begin
            hour_n = HOUR + 5'd1;
          end
        end else begin
          min_n = MIN + 6'd1;
        end
      end else begin
        sec_n = SEC + 6'd1;
      end
    end

    // MODE wins over UP in the same cycle.
    if (btn_mode) begin
      case (state)
        S_RUN:  state_n = S_HOUR;
        S_HOUR: state_n = S_MIN;
        S_MIN: begin
          state_n = S_RUN;
          sec_n   = '0;
          presc_n = '0;
        end
        default: state_n = S_RUN;
      endcase
    end else if (btn_up) begin
      if (state == S_HOUR) begin
        hour_n = (HOUR == 5'd23) ? 5'd0 : HOUR + 5'd1;
      end else if (state == S_MIN) begin
        min_n = (MIN == 6'd59) ? 6'd0 : MIN + 6'd1;
      end
    end

    if (btn_clr) begin
      sec_n   = '0;
      presc_n = '0;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  localparam int F = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] BTN = 3'b000;
  logic [4:0] HOUR;
  logic [5:0] MIN;
  logic [5:0] SEC;
  logic [1:0] MODE;
  logic       BLANK_H;
  logic       BLANK_M;
  logic       DAY_PULSE;

  int checks = 0;
  int errors = 0;

  // Reference model: time of day as seconds since midnight.
  int m_tod   = 0;
  int m_mode  = 0;
  int m_presc = 0;
  bit m_bh    = 0;
  bit m_bm    = 0;
  bit m_day   = 0;

  clock_set_ctrl #(.CLK_FREQ(F)) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .MODE(MODE),
    .BLANK_H(BLANK_H), .BLANK_M(BLANK_M), .DAY_PULSE(DAY_PULSE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] b, input logic r);
    int h, mi, s;
    bit tick, half;
    if (!r) begin
      m_tod = 0; m_mode = 0; m_presc = 0;
      m_bh = 0; m_bm = 0; m_day = 0;
      return;
    end
    tick  = (m_presc == F - 1);
    half  = (m_presc >= F / 2);
    m_bh  = (m_mode == 1) && half;
    m_bm  = (m_mode == 2) && half;
    m_day = 0;
    m_presc = tick ? 0 : m_presc + 1;
    if (m_mode == 0 && tick && !b[2]) begin
      m_tod = (m_tod + 1) % 86400;
      m_day = (m_tod == 0);
    end
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    if (b[0]) begin
      if (m_mode == 2) begin
        s = 0;
        m_presc = 0;
      end
      m_mode = (m_mode + 1) % 3;
    end else if (b[1]) begin
      if (m_mode == 1) h = (h + 1) % 24;
      else if (m_mode == 2) mi = (mi + 1) % 60;
    end
    if (b[2]) begin
      s = 0;
      m_presc = 0;
    end
    m_tod = h * 3600 + mi * 60 + s;
  endtask

  task automatic check_all();
    chk("hour", 32'(HOUR), 32'(m_tod / 3600));
    chk("min", 32'(MIN), 32'((m_tod / 60) % 60));
    chk("sec", 32'(SEC), 32'(m_tod % 60));
    chk("mode", 32'(MODE), 32'(m_mode));
    chk("blank_h", 32'(BLANK_H), 32'(m_bh));
    chk("blank_m", 32'(BLANK_M), 32'(m_bm));
    chk("day_pulse", 32'(DAY_PULSE), 32'(m_day));
  endtask

  // One clock edge with the given buttons and reset level, then compare.
  task automatic cyc_r(input logic [2:0] b, input logic r);
    BTN = b;
    RST = r;
    @(posedge CLK);
    model_step(b, r);
    #1;
    BTN = 3'b000;
    RST = 1'b1;
    check_all();
  endtask

  task automatic cyc(input logic [2:0] b);
    cyc_r(b, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000);
  endtask

  task automatic press(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  initial begin
    int guard;
    logic [2:0] rb;
    logic rr;

    // Reset state
    cyc_r(3'b000, 1'b0);
    cyc_r(3'b000, 1'b0);
    chk("reset_hour", 32'(HOUR), 0);
    chk("reset_mode", 32'(MODE), 0);
    chk("reset_sec", 32'(SEC), 0);

    // First SEC increment at edge F after reset release
    idle(F - 1);
    chk("first_tick_pre", 32'(SEC), 0);
    idle(1);
    chk("first_tick", 32'(SEC), 1);

    // Setting sequence
    cyc(3'b001);
    chk("set_mode1", 32'(MODE), 1);
    press(3'b010, 25);
    cyc(3'b001);
    chk("set_mode2", 32'(MODE), 2);
    press(3'b010, 61);
    cyc(3'b001);
    chk("set_mode0", 32'(MODE), 0);
    chk("set_hour", 32'(HOUR), 1);
    chk("set_min", 32'(MIN), 1);
    chk("set_sec", 32'(SEC), 0);

    // Preset 23:59 and roll over the day
    cyc(3'b001);
    press(3'b010, 22);
    cyc(3'b001);
    press(3'b010, 58);
    cyc(3'b001);
    chk("preset_hour", 32'(HOUR), 23);
    chk("preset_min", 32'(MIN), 59);
    idle(599);
    chk("pre_roll_sec", 32'(SEC), 59);
    chk("pre_roll_day", 32'(DAY_PULSE), 0);
    idle(1);
    chk("roll_hour", 32'(HOUR), 0);
    chk("roll_min", 32'(MIN), 0);
    chk("roll_sec", 32'(SEC), 0);
    chk("roll_day", 32'(DAY_PULSE), 1);
    idle(1);
    chk("roll_day_end", 32'(DAY_PULSE), 0);

    // Freeze in SET_HOUR with blinking hour field
    idle(33);
    cyc(3'b001);
    idle(35);
    chk("freeze_sec", 32'(SEC), 3);
    chk("freeze_blank_m", 32'(BLANK_M), 0);
    cyc(3'b001);
    cyc(3'b001);

    // MODE and UP together in RUN
    cyc(3'b011);
    chk("simul_mode", 32'(MODE), 1);
    chk("simul_hour", 32'(HOUR), 0);
    cyc(3'b001);
    cyc(3'b001);

    // SEC_CLR on the tick cycle
    idle(15);
    guard = 0;
    while (m_presc != F - 1 && guard < 2 * F) begin
      cyc(3'b000);
      guard++;
    end
    cyc(3'b100);
    chk("clr_tick_sec", 32'(SEC), 0);
    idle(F - 1);
    chk("clr_hold_sec", 32'(SEC), 0);
    idle(1);
    chk("clr_next_sec", 32'(SEC), 1);

    // UP ignored in RUN
    press(3'b010, 3);
    chk("run_up_hour", 32'(HOUR), 0);
    chk("run_up_min", 32'(MIN), 0);

    // Reset while in SET_MIN at 05:07
    cyc(3'b001);
    press(3'b010, 5);
    cyc(3'b001);
    press(3'b010, 7);
    chk("pre_rst_mode", 32'(MODE), 2);
    chk("pre_rst_hour", 32'(HOUR), 5);
    chk("pre_rst_min", 32'(MIN), 7);
    idle(6);
    cyc_r(3'b010, 1'b0);
    chk("mid_rst_mode", 32'(MODE), 0);
    chk("mid_rst_hour", 32'(HOUR), 0);
    chk("mid_rst_min", 32'(MIN), 0);
    chk("mid_rst_sec", 32'(SEC), 0);
    chk("mid_rst_bh", 32'(BLANK_H), 0);
    chk("mid_rst_bm", 32'(BLANK_M), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rb[0] = ($urandom_range(0, 39) == 0);
      rb[1] = ($urandom_range(0, 5) == 0);
      rb[2] = ($urandom_range(0, 59) == 0);
      rr    = ($urandom_range(0, 499) != 0);
      cyc_r(rb, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
